// File: rtl/out_sram_arbiter.sv
// Round-robin arbiter that hands the output SRAM write port to one edge-buffer bank per stream.
// It forwards the owner's beats with one cycle of latency and closes stalled streams on timeout.
module out_sram_arbiter #(
    parameter int unsigned NUM_BANK = 4,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NODE_W   = 8,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_BANK-1:0]        bank_req,
    output logic [NUM_BANK-1:0]        bank_grant,
    input  logic [NUM_BANK-1:0]        bank_valid,
    input  logic [NUM_BANK-1:0]        bank_sos,
    input  logic [NUM_BANK-1:0]        bank_eos,
    input  logic [NUM_BANK*DATA_W-1:0] bank_data,
    input  logic [NUM_BANK*NODE_W-1:0] bank_node_id,
    input  logic                       sram_busy,
    output logic                       sram_wr_valid,
    output logic                       sram_sos,
    output logic                       sram_eos,
    output logic [DATA_W-1:0]          sram_data,
    output logic [NODE_W-1:0]          sram_node_id,
    output logic                       arb_busy,
    output logic                       err_timeout,
    output logic                       err_collide,
    output logic [15:0]                txn_cnt
);

    localparam int unsigned PtrW = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic {StIdle, StStream} state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]     owner_q, owner_d;
    logic [CntW-1:0]     idle_cnt_q, idle_cnt_d;
    logic                wr_valid_q, wr_valid_d;
    logic                sos_q, sos_d;
    logic                eos_q, eos_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NODE_W-1:0]   node_q, node_d;
    logic                err_timeout_q, err_timeout_d;
    logic                err_collide_q, err_collide_d;
    logic [15:0]         txn_cnt_q, txn_cnt_d;

    logic                gnt_found;
    logic [PtrW-1:0]     gnt_idx;
    logic [NUM_BANK-1:0] owner_oh;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        if (32'(p) == NUM_BANK - 1) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    // First requester at or after rr_ptr, wrapping; only offered in IDLE with the SRAM free.
    always_comb begin
        int unsigned cand;
        gnt_found  = 1'b0;
        gnt_idx    = '0;
        bank_grant = '0;
        cand       = 0;
        if (reset && (state_q == StIdle) && !sram_busy) begin
            for (int unsigned i = 0; i < NUM_BANK; i++) begin
                cand = (32'(rr_ptr_q) + i) % NUM_BANK;
                if (!gnt_found && bank_req[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = PtrW'(cand);
                end
            end
            if (gnt_found) begin
                bank_grant[gnt_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        idle_cnt_d    = idle_cnt_q;
        wr_valid_d    = 1'b0;
        sos_d         = 1'b0;
        eos_d         = 1'b0;
        data_d        = '0;
        node_d        = '0;
        err_timeout_d = err_timeout_q;
        err_collide_d = err_collide_q;
        txn_cnt_d     = txn_cnt_q;

        unique case (state_q)
            StIdle: begin
                if ((bank_valid & ~bank_grant) != '0) begin
                    err_collide_d = 1'b1;
                end
                if (gnt_found) begin
                    if (bank_valid[gnt_idx] && bank_sos[gnt_idx]) begin
                        wr_valid_d = 1'b1;
                        sos_d      = 1'b1;
                        eos_d      = bank_eos[gnt_idx];
                        data_d     = bank_data[32'(gnt_idx)*DATA_W +: DATA_W];
                        node_d     = bank_node_id[32'(gnt_idx)*NODE_W +: NODE_W];
                    end
                    if (bank_valid[gnt_idx] && bank_sos[gnt_idx] && bank_eos[gnt_idx]) begin
                        rr_ptr_d = next_ptr(gnt_idx);
                        if (txn_cnt_q != 16'hFFFF) begin
                            txn_cnt_d = txn_cnt_q + 16'd1;
                        end
                    end else begin
                        state_d    = StStream;
                        owner_d    = gnt_idx;
                        idle_cnt_d = '0;
                    end
                end
            end
            StStream: begin
                if ((bank_valid & ~owner_oh) != '0) begin
                    err_collide_d = 1'b1;
                end
                if (bank_valid[owner_q]) begin
                    wr_valid_d = 1'b1;
                    sos_d      = bank_sos[owner_q];
                    eos_d      = bank_eos[owner_q];
                    data_d     = bank_data[32'(owner_q)*DATA_W +: DATA_W];
                    node_d     = bank_node_id[32'(owner_q)*NODE_W +: NODE_W];
                    idle_cnt_d = '0;
                    if (bank_eos[owner_q]) begin
                        state_d  = StIdle;
                        rr_ptr_d = next_ptr(owner_q);
                        if (txn_cnt_q != 16'hFFFF) begin
                            txn_cnt_d = txn_cnt_q + 16'd1;
                        end
                    end
                end else if (idle_cnt_q == CntW'(TIMEOUT - 1)) begin
                    // Stalled owner: emit an empty eos beat so the SRAM side sees the stream end.
                    err_timeout_d = 1'b1;
                    state_d       = StIdle;
                    rr_ptr_d      = next_ptr(owner_q);
                    idle_cnt_d    = '0;
                    wr_valid_d    = 1'b1;
                    eos_d         = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            idle_cnt_q    <= '0;
            wr_valid_q    <= 1'b0;
            sos_q         <= 1'b0;
            eos_q         <= 1'b0;
            data_q        <= '0;
            node_q        <= '0;
            err_timeout_q <= 1'b0;
            err_collide_q <= 1'b0;
            txn_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            idle_cnt_q    <= idle_cnt_d;
            wr_valid_q    <= wr_valid_d;
            sos_q         <= sos_d;
            eos_q         <= eos_d;
            data_q        <= data_d;
            node_q        <= node_d;
            err_timeout_q <= err_timeout_d;
            err_collide_q <= err_collide_d;
            txn_cnt_q     <= txn_cnt_d;
        end
    end

    assign sram_wr_valid = wr_valid_q;
    assign sram_sos      = sos_q;
    assign sram_eos      = eos_q;
    assign sram_data     = data_q;
    assign sram_node_id  = node_q;
    assign arb_busy      = (state_q == StStream);
    assign err_timeout   = err_timeout_q;
    assign err_collide   = err_collide_q;
    assign txn_cnt       = txn_cnt_q;

endmodule

// File: tb/tb_out_sram_arbiter.sv
// Bench for out_sram_arbiter: directed scenarios followed by randomized traffic, all outputs
// compared every cycle against a behavioural stream-ownership model.
module tb_out_sram_arbiter;

    localparam int NB = 4;
    localparam int DW = 16;
    localparam int NW = 8;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [NB-1:0]     bank_req, bank_grant, bank_valid, bank_sos, bank_eos;
    logic [NB*DW-1:0]  bank_data;
    logic [NB*NW-1:0]  bank_node_id;
    logic              sram_busy;
    logic              sram_wr_valid, sram_sos, sram_eos;
    logic [DW-1:0]     sram_data;
    logic [NW-1:0]     sram_node_id;
    logic              arb_busy, err_timeout, err_collide;
    logic [15:0]       txn_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the port, where the rotation resumes, expected output beat.
    bit m_stream, m_tout, m_coll;
    int m_ptr, m_owner, m_idle, m_cnt;
    bit e_v, e_sos, e_eos;
    int e_data, e_node;

    always #5 clk = ~clk;

    out_sram_arbiter #(
        .NUM_BANK(NB),
        .DATA_W  (DW),
        .NODE_W  (NW),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bank_req     (bank_req),
        .bank_grant   (bank_grant),
        .bank_valid   (bank_valid),
        .bank_sos     (bank_sos),
        .bank_eos     (bank_eos),
        .bank_data    (bank_data),
        .bank_node_id (bank_node_id),
        .sram_busy    (sram_busy),
        .sram_wr_valid(sram_wr_valid),
        .sram_sos     (sram_sos),
        .sram_eos     (sram_eos),
        .sram_data    (sram_data),
        .sram_node_id (sram_node_id),
        .arb_busy     (arb_busy),
        .err_timeout  (err_timeout),
        .err_collide  (err_collide),
        .txn_cnt      (txn_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NB-1:0] req);
        for (int i = 0; i < NB; i++) begin
            if (req[(m_ptr + i) % NB]) return (m_ptr + i) % NB;
        end
        return -1;
    endfunction

    task automatic forward(input int b);
        e_v    = 1'b1;
        e_sos  = bank_sos[b];
        e_eos  = bank_eos[b];
        e_data = int'(bank_data[b*DW +: DW]);
        e_node = int'(bank_node_id[b*NW +: NW]);
    endtask

    task automatic end_stream(input int b, input bit completed);
        m_stream = 1'b0;
        m_ptr    = (b + 1) % NB;
        if (completed && m_cnt < 65535) m_cnt++;
    endtask

    task automatic model_update(input int g);
        logic [NB-1:0] allowed;
        {e_v, e_sos, e_eos} = 3'b000;
        e_data = 0;
        e_node = 0;
        if (reset !== 1'b1) begin
            {m_stream, m_tout, m_coll} = 3'b000;
            m_ptr = 0; m_owner = 0; m_idle = 0; m_cnt = 0;
            return;
        end
        allowed = '0;
        if (!m_stream) begin
            if (g >= 0) allowed[g] = 1'b1;
            if ((bank_valid & ~allowed) != '0) m_coll = 1'b1;
            if (g >= 0) begin
                if (bank_valid[g] && bank_sos[g]) forward(g);
                if (bank_valid[g] && bank_sos[g] && bank_eos[g]) begin
                    end_stream(g, 1'b1);
                end else begin
                    m_stream = 1'b1;
                    m_owner  = g;
                    m_idle   = 0;
                end
            end
        end else begin
            allowed[m_owner] = 1'b1;
            if ((bank_valid & ~allowed) != '0) m_coll = 1'b1;
            if (bank_valid[m_owner]) begin
                forward(m_owner);
                m_idle = 0;
                if (bank_eos[m_owner]) end_stream(m_owner, 1'b1);
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_tout = 1'b1;
                    e_v    = 1'b1;
                    e_eos  = 1'b1;
                    m_idle = 0;
                    end_stream(m_owner, 1'b0);
                end
            end
        end
    endtask

    // One clock: check the combinational grant, advance the model, check the registered outputs.
    task automatic cycle();
        int g;
        logic [NB-1:0] exp_g;
        g = (reset === 1'b1 && !m_stream && !sram_busy) ? pick(bank_req) : -1;
        exp_g = '0;
        if (g >= 0) exp_g[g] = 1'b1;
        #3;
        check_eq("grant", 32'(bank_grant), 32'(exp_g));
        model_update(g);
        @(posedge clk);
        #1;
        check_eq("wr_valid", 32'(sram_wr_valid), 32'(e_v));
        check_eq("sos", 32'(sram_sos), 32'(e_sos));
        check_eq("eos", 32'(sram_eos), 32'(e_eos));
        check_eq("data", 32'(sram_data), 32'(e_data));
        check_eq("node_id", 32'(sram_node_id), 32'(e_node));
        check_eq("arb_busy", 32'(arb_busy), 32'(m_stream));
        check_eq("err_timeout", 32'(err_timeout), 32'(m_tout));
        check_eq("err_collide", 32'(err_collide), 32'(m_coll));
        check_eq("txn_cnt", 32'(txn_cnt), 32'(m_cnt));
    endtask

    task automatic drive(input bit rst, input logic [NB-1:0] req, input bit busy,
                         input logic [NB-1:0] v, input logic [NB-1:0] s, input logic [NB-1:0] e);
        reset      = rst;
        bank_req   = req;
        sram_busy  = busy;
        bank_valid = v;
        bank_sos   = s;
        bank_eos   = e;
    endtask

    task automatic gen_random(input int stall_pct);
        int g;
        reset        = ($urandom % 300) != 0;
        sram_busy    = ($urandom % 5) == 0;
        bank_req     = NB'($urandom & $urandom);
        bank_data    = {$urandom, $urandom};
        bank_node_id = $urandom;
        bank_valid   = '0;
        bank_sos     = '0;
        bank_eos     = '0;
        if (m_stream) begin
            if (int'($urandom % 100) >= stall_pct) begin
                bank_valid[m_owner] = 1'b1;
                bank_sos[m_owner]   = ($urandom % 8) == 0;
                bank_eos[m_owner]   = ($urandom % 5) == 0;
            end
        end else begin
            g = sram_busy ? -1 : pick(bank_req);
            if (g >= 0 && ($urandom % 6) != 0) begin
                bank_valid[g] = 1'b1;
                bank_sos[g]   = 1'b1;
                bank_eos[g]   = ($urandom % 3) == 0;
            end
        end
        if (($urandom % 60) == 0) bank_valid[$urandom % NB] = 1'b1;
    endtask

    initial begin
        bank_data    = '0;
        bank_node_id = 32'h44332211;
        m_stream = 0; m_tout = 0; m_coll = 0;
        m_ptr = 0; m_owner = 0; m_idle = 0; m_cnt = 0;
        drive(1'b0, '0, 1'b0, '0, '0, '0);
        @(posedge clk);
        #1;
        cycle();
        cycle();
        check_eq("reset_txn", 32'(txn_cnt), 32'd0);

        // Bank 1 four-beat stream.
        bank_data[1*DW +: DW] = 16'h0102;
        drive(1'b1, 4'b0010, 1'b0, 4'b0010, 4'b0010, 4'b0000);
        cycle();
        bank_data[1*DW +: DW] = 16'h0304;
        drive(1'b1, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000);
        cycle();
        check_eq("s4_beat1", 32'(sram_data), 32'h0304);
        bank_data[1*DW +: DW] = 16'h0506;
        cycle();
        bank_data[1*DW +: DW] = 16'h0708;
        drive(1'b1, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0010);
        cycle();
        check_eq("s4_last", 32'({sram_eos, sram_data}), 32'h10708);
        check_eq("s4_txn", 32'(txn_cnt), 32'd1);

        // rr_ptr now 2: banks 1 and 3 requesting must go to bank 3, single beat.
        drive(1'b1, 4'b1010, 1'b0, 4'b1000, 4'b1000, 4'b1000);
        #3;
        check_eq("rr_wrap_grant", 32'(bank_grant), 32'h8);
        cycle();
        check_eq("single_busy", 32'(arb_busy), 32'd0);
        check_eq("single_txn", 32'(txn_cnt), 32'd2);

        // Busy SRAM holds off a grant to bank 3.
        drive(1'b1, 4'b1000, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        #3;
        check_eq("busy_nogrant", 32'(bank_grant), 32'd0);
        cycle();
        drive(1'b1, 4'b1000, 1'b0, 4'b1000, 4'b1000, 4'b1000);
        cycle();

        // Reset in the middle of a bank 2 stream.
        drive(1'b1, 4'b0100, 1'b0, 4'b0100, 4'b0100, 4'b0000);
        cycle();
        drive(1'b0, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0000);
        cycle();
        check_eq("rst_mid_busy", 32'(arb_busy), 32'd0);
        check_eq("rst_mid_txn", 32'(txn_cnt), 32'd0);
        check_eq("rst_mid_valid", 32'(sram_wr_valid), 32'd0);

        // Collision during a bank 0 stream, then a full timeout.
        drive(1'b1, 4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0000);
        cycle();
        drive(1'b1, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000);
        cycle();
        check_eq("collide_flag", 32'(err_collide), 32'd1);
        check_eq("collide_drop", 32'(sram_wr_valid), 32'd0);
        drive(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        repeat (TO - 1) cycle();
        check_eq("tout_flag", 32'(err_timeout), 32'd1);
        check_eq("tout_close", 32'({sram_wr_valid, sram_eos, sram_data}), 32'h30000);
        check_eq("tout_idle", 32'(arb_busy), 32'd0);

        // Randomized traffic: normal streams, then a stall-heavy phase for timeouts.
        drive(1'b0, '0, 1'b0, '0, '0, '0);
        cycle();
        for (int n = 0; n < 3000; n++) begin
            gen_random(40);
            cycle();
        end
        for (int n = 0; n < 2000; n++) begin
            gen_random(97);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
